spiflash_responder: RTL and testbench

//  SPI mode-0 flash responder: the device side of the spiflash controller's link.

---
 rtl/spiflash_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_spiflash_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_responder.sv
// spiflash_responder: device side of a SPI mode-0 flash link.
// Decodes commands on cs_n/sck/mosi and answers on miso from a byte-wide
// backing memory. The SPI pins are oversampled in the i_clk domain, so SCK
// must run at i_clk/8 or slower.
// Optional feature: define SPIFLASH_RESP_WRITE_EN to enable WREN (0x06),
// WRDI (0x04) and PROGRAM (0x02); without it those commands are ignored,
// WEL stays 0 and the write port is tied off.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | CS_n high, nothing in progress
// ST_CMD    | shifting in the command byte
// ST_ADDR   | shifting in the 24-bit address (read or program)
// ST_DATA   | streaming memory bytes on MISO, prefetching the next one
// ST_ID     | returning the JEDEC ID, then 0x00
// ST_STATUS | returning the status byte repeatedly
// ST_IGNORE | unsupported/finished command, wait for CS_n rise
// ST_PROG   | each completed MOSI byte becomes one memory write
module spiflash_responder #(
    parameter int          MEM_AW      = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_sck,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_data,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STATUS,
        ST_IGNORE,
        ST_PROG
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_q, cs_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   cs_fall, cs_rise, cs_evt;
    logic                   sck_rise, sck_fall;

    logic [2:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        in_byte;
    logic              byte_done;
    logic [4:0]        addr_cnt;
    logic              addr_done;
    logic [7:0]        out_shift;
    logic [2:0]        out_cnt;
    logic [1:0]        id_idx;
    logic [7:0]        id_next;
    logic              resp_state;
    logic              miso, miso_oe;
    logic              mem_rd, mem_rd_q;
    logic [MEM_AW-1:0] mem_addr;

    logic              wel;
    logic              is_prog;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        status_byte;

    // Pin synchronizers plus one extra sample for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_fall = cs_q & ~cs_s;
    assign cs_rise = ~cs_q & cs_s;
    assign cs_evt  = cs_fall | cs_rise;

    // A CS_n edge in the same sample wins over any SCK edge.
    assign sck_rise = ~cs_evt & ~cs_s & sck_s & ~sck_q;
    assign sck_fall = ~cs_evt & ~cs_s & ~sck_s & sck_q;

    assign in_byte     = {shift_in, mosi_s};
    assign byte_done   = sck_rise & (bit_cnt == 3'd7);
    assign addr_done   = sck_rise & (addr_cnt == 5'd23);
    assign status_byte = {6'b0, wel, 1'b0};
    assign resp_state  = (state == ST_DATA) || (state == ST_ID) || (state == ST_STATUS);

    // ID bytes after the first one: remaining JEDEC bytes, then zeros.
    always_comb begin
        id_next = 8'h00;
        case (id_idx)
            2'd1:    id_next = JEDEC_ID[15:8];
            2'd2:    id_next = JEDEC_ID[7:0];
            default: id_next = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = ST_IDLE;
        end else if (cs_fall) begin
            state_nxt = ST_CMD;
        end else begin
            case (state)
                ST_CMD: begin
                    if (byte_done) begin
                        case (in_byte)
                            8'h03:   state_nxt = ST_ADDR;
                            8'h9F:   state_nxt = ST_ID;
                            8'h05:   state_nxt = ST_STATUS;
`ifdef SPIFLASH_RESP_WRITE_EN
                            8'h02:   state_nxt = wel ? ST_ADDR : ST_IGNORE;
`endif
                            default: state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (addr_done) state_nxt = is_prog ? ST_PROG : ST_DATA;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Serial datapath: shift-in, address capture, response shift-out, read strobes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            addr_cnt  <= '0;
            out_shift <= '0;
            out_cnt   <= '0;
            id_idx    <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_addr  <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_rd_q <= mem_rd;
            // Address advances the cycle after a write strobe so the strobe sees the current address.
            if (mem_we) mem_addr <= mem_addr + MEM_AW'(1);
            if (cs_evt) begin
                bit_cnt  <= '0;
                addr_cnt <= '0;
                out_cnt  <= '0;
                miso     <= 1'b0;
                miso_oe  <= 1'b0;
            end else begin
                if (sck_rise) begin
                    shift_in <= in_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (state == ST_ADDR) begin
                        // Only the low MEM_AW address bits survive the shift.
                        mem_addr <= {mem_addr[MEM_AW-2:0], mosi_s};
                        addr_cnt <= addr_done ? 5'd0 : addr_cnt + 5'd1;
                        if (addr_done) mem_rd <= ~is_prog;
                    end
                    if (state == ST_CMD && byte_done) begin
                        out_cnt <= '0;
                        case (in_byte)
                            8'h9F: begin
                                out_shift <= JEDEC_ID[23:16];
                                id_idx    <= 2'd1;
                            end
                            8'h05:   out_shift <= status_byte;
                            default: out_shift <= out_shift;
                        endcase
                    end
                end
                if (sck_fall && resp_state) begin
                    miso    <= out_shift[7];
                    miso_oe <= 1'b1;
                    out_cnt <= out_cnt + 3'd1;
                    if (out_cnt == 3'd7) begin
                        case (state)
                            ST_DATA: begin
                                mem_addr  <= mem_addr + MEM_AW'(1);
                                mem_rd    <= 1'b1;
                                out_shift <= {out_shift[6:0], 1'b0};
                            end
                            ST_ID: begin
                                out_shift <= id_next;
                                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                            end
                            default: out_shift <= status_byte;
                        endcase
                    end else begin
                        out_shift <= {out_shift[6:0], 1'b0};
                    end
                end
            end
            // Read data arrives the cycle after the strobe.
            if (mem_rd_q && state == ST_DATA) out_shift <= i_mem_data;
        end
    end

`ifdef SPIFLASH_RESP_WRITE_EN
    // Write-enable latch, program-session flag and write strobe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wel       <= 1'b0;
            is_prog   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (cs_rise) begin
                if (is_prog) wel <= 1'b0;
                is_prog <= 1'b0;
            end else if (cs_fall) begin
                is_prog <= 1'b0;
            end else if (state == ST_CMD && byte_done) begin
                case (in_byte)
                    8'h06:   wel     <= 1'b1;
                    8'h04:   wel     <= 1'b0;
                    8'h02:   is_prog <= wel;
                    default: wel     <= wel;
                endcase
            end else if (state == ST_PROG && byte_done) begin
                mem_we    <= 1'b1;
                mem_wdata <= in_byte;
            end
        end
    end
`else
    assign wel       = 1'b0;
    assign is_prog   = 1'b0;
    assign mem_we    = 1'b0;
    assign mem_wdata = 8'h00;
`endif

    assign o_spi_miso    = miso;
    assign o_spi_miso_oe = miso_oe;
    assign o_mem_addr    = mem_addr;
    assign o_mem_rd      = mem_rd;
    assign o_mem_we      = mem_we;
    assign o_mem_wdata   = mem_wdata;
    assign o_busy        = ~cs_s;

endmodule

// File: tb/tb_spiflash_responder.sv
// Bench for spiflash_responder: drives a mode-0 SPI controller at i_clk/12,
// models a 64 KiB byte memory, and checks responses against values computed
// from the command rules (plain address arithmetic over the bench memory).
module tb_spiflash_responder;

    localparam int HALF = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs_n  = 1'b1;
    logic        sck   = 1'b0;
    logic        mosi  = 1'b0;
    logic        miso, miso_oe;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;

    always #5 clk = ~clk;

    spiflash_responder #(
        .MEM_AW     (16),
        .JEDEC_ID   (24'hEF4016),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_spi_cs_n   (cs_n),
        .i_spi_sck    (sck),
        .i_spi_mosi   (mosi),
        .o_spi_miso   (miso),
        .o_spi_miso_oe(miso_oe),
        .o_mem_addr   (mem_addr),
        .o_mem_rd     (mem_rd),
        .i_mem_data   (mem_data),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log[$];
    logic [15:0] we_addr_log[$];
    logic [7:0]  we_data_log[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic       oe_all_b [16];
    logic       oe_any_b [16];

    // Backing memory: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    // Strobe logs, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (mem_we) begin
            we_addr_log.push_back(mem_addr);
            we_data_log.push_back(mem_wdata);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_at(input int i);
        if (i < rd_log.size()) return rd_log[i];
        return 16'hxxxx;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_high();
        clks(HALF);
        cs_n = 1'b1;
        clks(HALF + 4);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                            output logic oe_all, output logic oe_any);
        rx     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = tx[i];
            clks(HALF);
            sck    = 1'b1;
            rx[i]  = miso;
            oe_all = oe_all & miso_oe;
            oe_any = oe_any | miso_oe;
            clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_raw(input int nbytes);
        logic [7:0] r;
        logic       a, y;
        cs_low();
        for (int k = 0; k < nbytes; k++) begin
            spi_bits(tx_buf[k], 8, r, a, y);
            rx_buf[k]   = r;
            oe_all_b[k] = a;
            oe_any_b[k] = y;
        end
        cs_high();
    endtask

    task automatic set_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        tx_buf[0] = cmd;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
        for (int k = 4; k < 16; k++) tx_buf[k] = 8'($urandom);
    endtask

    initial begin : main
        logic [7:0]  r;
        logic        a, y;
        logic [23:0] start;
        int          n, base;
        logic [7:0]  orig10, orig11, exp_st;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset values.
        #2 rst_n = 1'b0;
        clks(3);
        check("rst_miso", 32'(miso), 0);
        check("rst_oe", 32'(miso_oe), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        clks(4);

        // Read four bytes from 0x000100.
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        rd_log.delete();
        set_cmd_addr(8'h03, 24'h000100);
        spi_raw(8);
        check("rd1_b0", 32'(rx_buf[4]), 32'h11);
        check("rd1_b1", 32'(rx_buf[5]), 32'h22);
        check("rd1_b2", 32'(rx_buf[6]), 32'h33);
        check("rd1_b3", 32'(rx_buf[7]), 32'h44);
        for (int k = 0; k < 4; k++) check($sformatf("rd1_addr%0d", k), 32'(rd_at(k)), 32'h100 + k);
        check("rd1_hdr_oe", 32'(oe_any_b[0] | oe_any_b[1] | oe_any_b[2] | oe_any_b[3]), 0);
        check("rd1_data_oe", 32'(oe_all_b[4] & oe_all_b[7]), 1);
        check("rd1_oe_after", 32'(miso_oe), 0);

        // JEDEC ID.
        set_cmd_addr(8'h9F, 24'($urandom));
        spi_raw(5);
        check("id_b0", 32'(rx_buf[1]), 32'hEF);
        check("id_b1", 32'(rx_buf[2]), 32'h40);
        check("id_b2", 32'(rx_buf[3]), 32'h16);
        check("id_b3", 32'(rx_buf[4]), 32'h00);
        check("id_cmd_oe", 32'(oe_any_b[0]), 0);
        check("id_resp_oe", 32'(oe_all_b[1] & oe_all_b[2] & oe_all_b[3] & oe_all_b[4]), 1);

        // Address wrap at the top of a 16-bit memory.
        rd_log.delete();
        set_cmd_addr(8'h03, 24'h00FFFE);
        spi_raw(8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_addr%0d", k), 32'(rd_at(k)), (32'hFFFE + k) % 65536);
            check($sformatf("wrap_b%0d", k), 32'(rx_buf[4 + k]), 32'(mem[(32'hFFFE + k) % 65536]));
        end

        // CS_n raised after 13 address bits: no read, then status is 0x00.
        rd_log.delete();
        cs_low();
        spi_bits(8'h03, 8, r, a, y);
        spi_bits(8'h00, 8, r, a, y);
        check("abort_busy", 32'(busy), 1);
        spi_bits(8'h01, 5, r, a, y);
        cs_high();
        check("abort_no_rd", 32'(rd_log.size()), 0);
        check("abort_busy_low", 32'(busy), 0);
        set_cmd_addr(8'h05, 24'h000000);
        spi_raw(3);
        check("abort_status0", 32'(rx_buf[1]), 0);
        check("abort_status1", 32'(rx_buf[2]), 0);

        // Write commands: WREN, status, PROGRAM 0x000010 A5 5A, read back, status.
        orig10 = mem[16'h0010];
        orig11 = mem[16'h0011];
        we_addr_log.delete();
        we_data_log.delete();
        tx_buf[0] = 8'h06;
        spi_raw(1);
        set_cmd_addr(8'h05, 24'h000000);
        spi_raw(2);
`ifdef SPIFLASH_RESP_WRITE_EN
        exp_st = 8'h02;
`else
        exp_st = 8'h00;
`endif
        check("wren_status", 32'(rx_buf[1]), 32'(exp_st));
        set_cmd_addr(8'h02, 24'h000010);
        tx_buf[4] = 8'hA5;
        tx_buf[5] = 8'h5A;
        spi_raw(6);
        rd_log.delete();
        set_cmd_addr(8'h03, 24'h000010);
        spi_raw(6);
`ifdef SPIFLASH_RESP_WRITE_EN
        check("prog_we_count", 32'(we_addr_log.size()), 2);
        check("prog_we_addr0", 32'(we_addr_log.size() > 0 ? we_addr_log[0] : 16'hxxxx), 32'h10);
        check("prog_we_data1", 32'(we_data_log.size() > 1 ? we_data_log[1] : 8'hxx), 32'h5A);
        check("prog_rd0", 32'(rx_buf[4]), 32'hA5);
        check("prog_rd1", 32'(rx_buf[5]), 32'h5A);
`else
        check("prog_we_count", 32'(we_addr_log.size()), 0);
        check("prog_rd0", 32'(rx_buf[4]), 32'(orig10));
        check("prog_rd1", 32'(rx_buf[5]), 32'(orig11));
`endif
        set_cmd_addr(8'h05, 24'h000000);
        spi_raw(2);
        check("prog_status_after", 32'(rx_buf[1]), 0);

        // Reset asserted in the middle of a data byte.
        cs_low();
        spi_bits(8'h03, 8, r, a, y);
        spi_bits(8'h00, 8, r, a, y);
        spi_bits(8'h02, 8, r, a, y);
        spi_bits(8'h00, 8, r, a, y);
        spi_bits(8'h00, 8, r, a, y);
        spi_bits(8'h00, 3, r, a, y);
        check("mid_oe_before", 32'(miso_oe), 1);
        check("mid_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(miso), 0);
        check("mid_rst_oe", 32'(miso_oe), 0);
        check("mid_rst_rd", 32'(mem_rd), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_busy", 32'(busy), 0);
        cs_n = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        set_cmd_addr(8'h9F, 24'h000000);
        spi_raw(2);
        check("post_rst_id", 32'(rx_buf[1]), 32'hEF);

        // Randomized reads: any 24-bit start, 1..6 bytes.
        for (int it = 0; it < 8; it++) begin
            start = 24'($urandom);
            n     = int'($urandom_range(1, 6));
            base  = int'(start[15:0]);
            rd_log.delete();
            set_cmd_addr(8'h03, start);
            spi_raw(4 + n);
            for (int k = 0; k < n; k++) begin
                check($sformatf("rnd%0d_b%0d", it, k), 32'(rx_buf[4 + k]), 32'(mem[(base + k) % 65536]));
                check($sformatf("rnd%0d_a%0d", it, k), 32'(rd_at(k)), 32'((base + k) % 65536));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
